gpio_debounce: RTL and testbench

//  Input conditioning stage that sits directly upstream of the HBA GPIO peripheral.
//  Per pin, it synchronises the raw pad input into hba_clk and rejects glitches shorter than a programmable period.
//  It drives the clean level onto the peripheral's gpio_in_sig.
//  It also emits one-cycle rise/fall strobes for edge consumers such as interrupt logic.

---
 rtl/gpio_debounce_pkg.sv | 9 +
 rtl/gpio_debounce_pin.sv | 88 ++++++++
 rtl/gpio_debounce.sv | 47 ++++
 tb/tb_gpio_debounce.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/gpio_debounce_pkg.sv
// Shared constants for the GPIO input debounce stage.
//   GPIO_DB_DEFAULT_PERIOD  : db_period value giving a 1000-cycle stability window
//   GPIO_DB_MIN_SYNC_STAGES : shortest synchroniser chain the pin filter will build
package gpio_debounce_pkg;

   localparam logic [15:0]  GPIO_DB_DEFAULT_PERIOD  = 16'd999;
   localparam int unsigned  GPIO_DB_MIN_SYNC_STAGES = 2;

endpackage : gpio_debounce_pkg

// File: rtl/gpio_debounce_pin.sv
// Single-pin input conditioner: synchroniser chain, stability counter,
// registered debounced level and one-cycle edge strobes.
// Ports:
//   clk_i     : clock, all logic on posedge
//   rst_ni    : asynchronous active-low reset
//   pin_i     : raw asynchronous pad input
//   period_i  : required stable cycles minus one
//   bypass_i  : 1 = level follows the synchronised input directly
//   level_o   : debounced level
//   rise_o    : one-cycle pulse when level_o goes 0->1
//   fall_o    : one-cycle pulse when level_o goes 1->0
module gpio_debounce_pin
   import gpio_debounce_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 pin_i,
   input  logic [CNT_WIDTH-1:0] period_i,
   input  logic                 bypass_i,
   output logic                 level_o,
   output logic                 rise_o,
   output logic                 fall_o
);

   // A single flop is not a synchroniser; clamp to the minimum chain length.
   localparam int unsigned STAGES = (SYNC_STAGES < GPIO_DB_MIN_SYNC_STAGES) ?
                                    GPIO_DB_MIN_SYNC_STAGES : SYNC_STAGES;

   logic [STAGES-1:0]    sync_q, sync_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 level_q, level_d;
   logic                 rise_q, rise_d;
   logic                 fall_q, fall_d;
   logic                 s;

   assign s = sync_q[STAGES-1];

   always_comb begin
      sync_d  = {sync_q[STAGES-2:0], pin_i};
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;

      if (bypass_i) begin
         cnt_d   = '0;
         level_d = s;
         rise_d  = s & ~level_q;
         fall_d  = ~s & level_q;
      end else if (s == level_q) begin
         // Input agrees with the output again: drop any partial glitch.
         cnt_d = '0;
      end else if (cnt_q >= period_i) begin
         // >= rather than == so a period lowered below the running count
         // accepts on this edge instead of leaving the counter stranded.
         cnt_d   = '0;
         level_d = s;
         rise_d  = s;
         fall_d  = ~s;
      end else begin
         cnt_d = CNT_WIDTH'(cnt_q + 1'b1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule : gpio_debounce_pin

// File: rtl/gpio_debounce.sv
// Input conditioning stage ahead of the HBA GPIO peripheral. Each pin is
// synchronised into hba_clk, filtered for a programmable stability period,
// and presented as a clean level plus rise/fall strobes. All outputs are
// registered.
// Ports:
//   hba_clk     : system clock
//   hba_reset_n : asynchronous active-low reset
//   pin_in      : raw asynchronous pad inputs
//   db_period   : required stable cycles minus one (quasi-static)
//   db_bypass   : 1 = no filtering, pin_out follows the synchronised input
//   pin_out     : debounced levels (to gpio_in_sig)
//   pin_rise    : one-cycle pulse per pin on pin_out 0->1
//   pin_fall    : one-cycle pulse per pin on pin_out 1->0
module gpio_debounce
   import gpio_debounce_pkg::*;
#(
   parameter int unsigned NUM_PINS    = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                 hba_clk,
   input  logic                 hba_reset_n,
   input  logic [NUM_PINS-1:0]  pin_in,
   input  logic [CNT_WIDTH-1:0] db_period,
   input  logic                 db_bypass,
   output logic [NUM_PINS-1:0]  pin_out,
   output logic [NUM_PINS-1:0]  pin_rise,
   output logic [NUM_PINS-1:0]  pin_fall
);

   for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
      gpio_debounce_pin #(
         .SYNC_STAGES (SYNC_STAGES),
         .CNT_WIDTH   (CNT_WIDTH)
      ) u_pin (
         .clk_i    (hba_clk),
         .rst_ni   (hba_reset_n),
         .pin_i    (pin_in[i]),
         .period_i (db_period),
         .bypass_i (db_bypass),
         .level_o  (pin_out[i]),
         .rise_o   (pin_rise[i]),
         .fall_o   (pin_fall[i])
      );
   end

endmodule : gpio_debounce

// File: tb/tb_gpio_debounce.sv
module tb_gpio_debounce;

   localparam int unsigned NP   = 4;
   localparam int unsigned SYNC = 2;
   localparam int unsigned CW   = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NP-1:0] pin_in;
   logic [CW-1:0] db_period;
   logic          db_bypass;
   logic [NP-1:0] pin_out, pin_rise, pin_fall;

   int total = 0;
   int bad   = 0;

   gpio_debounce #(
      .NUM_PINS    (NP),
      .SYNC_STAGES (SYNC),
      .CNT_WIDTH   (CW)
   ) dut (
      .hba_clk     (clk),
      .hba_reset_n (rst_n),
      .pin_in      (pin_in),
      .db_period   (db_period),
      .db_bypass   (db_bypass),
      .pin_out     (pin_out),
      .pin_rise    (pin_rise),
      .pin_fall    (pin_fall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the filter input is pin_in seen SYNC edges ago; a
   // change is taken once the input has disagreed with the output on
   // db_period+1 consecutive edges (or immediately in bypass).
   logic [SYNC-1:0][NP-1:0] m_pipe;
   int                      m_streak [NP];
   logic [NP-1:0]           m_out, m_rise, m_fall;

   always @(posedge clk or negedge rst_n) begin : model
      logic [NP-1:0] s, nout, nr, nf;
      int            nstreak [NP];
      if (!rst_n) begin
         m_pipe <= '0;
         m_out  <= '0;
         m_rise <= '0;
         m_fall <= '0;
         for (int p = 0; p < NP; p++) m_streak[p] <= 0;
      end else begin
         s    = m_pipe[SYNC-1];
         nout = m_out;
         for (int p = 0; p < NP; p++) begin
            nstreak[p] = m_streak[p];
            if (s[p] == m_out[p]) nstreak[p] = 0;
            else if (db_bypass || m_streak[p] >= int'(db_period)) begin
               nout[p]    = s[p];
               nstreak[p] = 0;
            end else nstreak[p] = m_streak[p] + 1;
            if (db_bypass) nstreak[p] = 0;
         end
         nr = nout & ~m_out;
         nf = ~nout & m_out;
         m_out    <= nout;
         m_rise   <= nr;
         m_fall   <= nf;
         m_streak <= nstreak;
         m_pipe   <= {m_pipe[SYNC-2:0], pin_in};
      end
   end

   always @(negedge clk) begin
      chk("model_out",  32'(pin_out),  32'(m_out));
      chk("model_rise", 32'(pin_rise), 32'(m_rise));
      chk("model_fall", 32'(pin_fall), 32'(m_fall));
      chk("rise_and_fall", 32'(pin_rise & pin_fall), 32'd0);
   end

   initial begin
      pin_in    = '0;
      db_period = 16'd3;
      db_bypass = 1'b0;
      rst_n     = 1'b1;
      #1 rst_n  = 1'b0;
      #1;
      chk("reset_out",  32'(pin_out),  32'd0);
      chk("reset_rise", 32'(pin_rise), 32'd0);
      chk("reset_fall", 32'(pin_fall), 32'd0);
      repeat (2) @(negedge clk);

      // 1: release with all pins high, period 3 -> change after 6 edges
      pin_in = 4'hF;
      rst_n  = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         chk("t1_out",  32'(pin_out),  (k >= 6) ? 32'hF : 32'h0);
         chk("t1_rise", 32'(pin_rise), (k == 6) ? 32'hF : 32'h0);
      end
      pin_in = '0;
      repeat (8) @(negedge clk);
      chk("t1_settle", 32'(pin_out), 32'h0);

      // 2: 3-cycle glitch rejected, 4-cycle pulse accepted
      pin_in[0] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 3) pin_in[0] = 1'b0;
         chk("t2_glitch_out",  32'(pin_out[0]),  32'd0);
         chk("t2_glitch_rise", 32'(pin_rise[0]), 32'd0);
      end
      pin_in[0] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 4) pin_in[0] = 1'b0;
         chk("t2_pulse_out",  32'(pin_out[0]),  (k >= 6 && k < 10) ? 32'd1 : 32'd0);
         chk("t2_pulse_rise", 32'(pin_rise[0]), (k == 6) ? 32'd1 : 32'd0);
         chk("t2_pulse_fall", 32'(pin_fall[0]), (k == 10) ? 32'd1 : 32'd0);
      end

      // 3: period 0, pin 2 toggling every 4 cycles -> 3-cycle latency
      db_period = 16'd0;
      pin_in[2] = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         pin_in[2] = ((k / 4) % 2) == 0;
         chk("t3_out",  32'(pin_out[2]),
             (k >= 3 && ((k - 3) / 4) % 2 == 0) ? 32'd1 : 32'd0);
         chk("t3_rise", 32'(pin_rise[2]), (k == 3 || k == 11) ? 32'd1 : 32'd0);
         chk("t3_fall", 32'(pin_fall[2]), (k == 7 || k == 15) ? 32'd1 : 32'd0);
      end
      pin_in = '0;
      repeat (4) @(negedge clk);

      // 4: period 100, count reaches 50, then period lowered to 10
      db_period = 16'd100;
      pin_in[1] = 1'b1;
      repeat (52) @(negedge clk);
      chk("t4_before", 32'(pin_out[1]), 32'd0);
      db_period = 16'd10;
      @(negedge clk);
      chk("t4_after_out",  32'(pin_out[1]),  32'd1);
      chk("t4_after_rise", 32'(pin_rise[1]), 32'd1);
      pin_in = '0;
      repeat (16) @(negedge clk);
      chk("t4_settle", 32'(pin_out), 32'h0);

      // 5: bypass, pin_in=1010 shows up after 3 edges
      db_bypass = 1'b1;
      pin_in    = 4'b1010;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("t5_out",  32'(pin_out),  (k >= 3) ? 32'hA : 32'h0);
         chk("t5_rise", 32'(pin_rise), (k == 3) ? 32'hA : 32'h0);
      end
      pin_in = '0;
      repeat (4) @(negedge clk);
      chk("t5_off", 32'(pin_out), 32'h0);
      db_bypass = 1'b0;

      // bypass pulsed while a count is in progress
      db_period = 16'd3;
      pin_in    = 4'h5;
      repeat (3) @(negedge clk);
      db_bypass = 1'b1;
      @(negedge clk);
      db_bypass = 1'b0;
      pin_in    = 4'h6;
      repeat (10) @(negedge clk);

      // 6: asynchronous reset between edges while a fall is being counted
      pin_in = 4'hF;
      repeat (8) @(negedge clk);
      chk("t6_high", 32'(pin_out), 32'hF);
      pin_in = '0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_out",  32'(pin_out),  32'h0);
      chk("t6_rst_rise", 32'(pin_rise), 32'h0);
      chk("t6_rst_fall", 32'(pin_fall), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk("t6_post_out",    32'(pin_out),  32'h0);
         chk("t6_post_strobe", 32'(pin_rise | pin_fall), 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_gpio_debounce
